cond_decrement: RTL and testbench

Streaming inverse of the conditional-increment datapath. Each 32-bit word `b` produced by the conditional-increment stage is mapped back to its pre-image `a`. A word `b` arrives from the link and `a` is handed downstream through a 2-stage valid/ready pipeline. Two decode flags are attached to every output word:

- **ambiguous:** the word has two pre-images.
- **invalid:** the word has no pre-image.

---
 rtl/cond_inc_pkg.sv | 16 +
 rtl/cond_decrement_core.sv | 26 ++
 rtl/cond_decrement.sv | 149 ++++++++++++++
 tb/tb_cond_decrement.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/cond_inc_pkg.sv
// Shared constants and types for the conditional-increment / decrement pair.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cond_inc_pkg;

   localparam int              DEFAULT_WIDTH  = 32;
   localparam longint unsigned DEFAULT_THRESH = 64'd4096;
   localparam int              STAT_W         = 16;

   // Decode flags travelling alongside every output word.
   typedef struct packed {
      logic ambig;    // word had two pre-images (b == THRESH+1)
      logic invalid;  // word had no pre-image   (b == 0)
   } dec_flags_t;

endpackage

// File: rtl/cond_decrement_core.sv
// Combinational inverse of the conditional increment: b -> a, flags pass through.
// Latency: 0 cycles (pure logic between pipeline stages).
// Backpressure: none; the enclosing pipeline owns all flow control.
module cond_decrement_core
   import cond_inc_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic [WIDTH-1:0] b_i,
   input  logic             le_p1_i,   // registered (b <= THRESH+1)
   input  dec_flags_t       flags_i,
   output logic [WIDTH-1:0] a_o,
   output dec_flags_t       flags_o
);

   // Decrement only inside the incremented range; zero has no pre-image and
   // must not wrap to all-ones, so it passes through unchanged.
   always_comb begin
      a_o     = b_i;
      flags_o = flags_i;
      if (le_p1_i && !flags_i.invalid) begin
         a_o = b_i - WIDTH'(1);
      end
   end

endmodule

// File: rtl/cond_decrement.sv
// Two-stage valid/ready decoder mapping encoded word b back to a, with ambig/invalid flags.
// Latency: 2 cycles from acceptance to out_valid; 1 word per cycle sustained.
// Backpressure: ready_k = !valid_k || ready_{k+1}; in_ready is combinational from out_ready.
// Optional counters ambig_cnt/invalid_cnt exist only when COND_DECREMENT_STATS_EN is defined.
module cond_decrement
   import cond_inc_pkg::*;
#(
   parameter int              WIDTH  = DEFAULT_WIDTH,
   parameter longint unsigned THRESH = DEFAULT_THRESH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ambig,
   output logic             out_invalid
`ifdef COND_DECREMENT_STATS_EN
   ,
   output logic [STAT_W-1:0] ambig_cnt,
   output logic [STAT_W-1:0] invalid_cnt
`endif
);

   // THRESH+1 must be representable, otherwise the ambiguous code point vanishes.
   if (THRESH >= ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_thresh
      $error("cond_decrement: THRESH must be below 2**WIDTH-1");
   end

   localparam logic [WIDTH-1:0] THRESH_P1 = WIDTH'(THRESH + 64'd1);

   logic             s1_vld_q, s1_vld_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic             s1_le_q, s1_le_d;
   dec_flags_t       s1_flg_q, s1_flg_d;

   logic             s2_vld_q, s2_vld_d;
   logic [WIDTH-1:0] s2_a_q, s2_a_d;
   dec_flags_t       s2_flg_q, s2_flg_d;

   logic             rdy1, rdy2;
   logic [WIDTH-1:0] core_a;
   dec_flags_t       core_flg;

   assign rdy2     = !s2_vld_q || out_ready;
   assign rdy1     = !s1_vld_q || rdy2;
   assign in_ready = rdy1;

   cond_decrement_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .b_i     (s1_b_q),
      .le_p1_i (s1_le_q),
      .flags_i (s1_flg_q),
      .a_o     (core_a),
      .flags_o (core_flg)
   );

   // Next-state for both stages: load when the stage is free or being drained.
   always_comb begin
      s1_vld_d = s1_vld_q;
      s1_b_d   = s1_b_q;
      s1_le_d  = s1_le_q;
      s1_flg_d = s1_flg_q;
      s2_vld_d = s2_vld_q;
      s2_a_d   = s2_a_q;
      s2_flg_d = s2_flg_q;
      if (rdy1) begin
         s1_vld_d = in_valid;
         if (in_valid) begin
            s1_b_d           = in_data;
            s1_le_d          = (in_data <= THRESH_P1);
            s1_flg_d.ambig   = (in_data == THRESH_P1);
            s1_flg_d.invalid = (in_data == '0);
         end
      end
      if (rdy2) begin
         s2_vld_d = s1_vld_q;
         if (s1_vld_q) begin
            s2_a_d   = core_a;
            s2_flg_d = core_flg;
         end
      end
   end

   // Pipeline registers; reset discards anything in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_q <= 1'b0;
         s1_b_q   <= '0;
         s1_le_q  <= 1'b0;
         s1_flg_q <= '0;
         s2_vld_q <= 1'b0;
         s2_a_q   <= '0;
         s2_flg_q <= '0;
      end else begin
         s1_vld_q <= s1_vld_d;
         s1_b_q   <= s1_b_d;
         s1_le_q  <= s1_le_d;
         s1_flg_q <= s1_flg_d;
         s2_vld_q <= s2_vld_d;
         s2_a_q   <= s2_a_d;
         s2_flg_q <= s2_flg_d;
      end
   end

   assign out_valid   = s2_vld_q;
   assign out_data    = s2_a_q;
   assign out_ambig   = s2_flg_q.ambig;
   assign out_invalid = s2_flg_q.invalid;

`ifdef COND_DECREMENT_STATS_EN
   logic [STAT_W-1:0] ambig_cnt_q, ambig_cnt_d;
   logic [STAT_W-1:0] invalid_cnt_q, invalid_cnt_d;
   logic              xfer;

   assign xfer = s2_vld_q && out_ready;

   // Count flagged words only on real output transfers, saturating at all-ones.
   always_comb begin
      ambig_cnt_d   = ambig_cnt_q;
      invalid_cnt_d = invalid_cnt_q;
      if (xfer && s2_flg_q.ambig && (ambig_cnt_q != '1)) begin
         ambig_cnt_d = ambig_cnt_q + STAT_W'(1);
      end
      if (xfer && s2_flg_q.invalid && (invalid_cnt_q != '1)) begin
         invalid_cnt_d = invalid_cnt_q + STAT_W'(1);
      end
   end

   // Statistics registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ambig_cnt_q   <= '0;
         invalid_cnt_q <= '0;
      end else begin
         ambig_cnt_q   <= ambig_cnt_d;
         invalid_cnt_q <= invalid_cnt_d;
      end
   end

   assign ambig_cnt   = ambig_cnt_q;
   assign invalid_cnt = invalid_cnt_q;
`endif

endmodule

// File: tb/tb_cond_decrement.sv
// Directed bench for cond_decrement: decode table, invalid word, stall, reset, round trip, stats.
module tb_cond_decrement;
   import cond_inc_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, out_valid, out_ambig, out_invalid;
   logic [31:0] out_data;
`ifdef COND_DECREMENT_STATS_EN
   logic [15:0] ambig_cnt, invalid_cnt;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   logic [33:0] oq[$];   // {ambig, invalid, data}
   int          ocyc[$];
   int          acyc[$];

   cond_decrement dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_ambig   (out_ambig),
      .out_invalid (out_invalid)
`ifdef COND_DECREMENT_STATS_EN
      ,
      .ambig_cnt   (ambig_cnt),
      .invalid_cnt (invalid_cnt)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst_n && in_valid && in_ready) acyc.push_back(cyc);
      if (rst_n && out_valid && out_ready) begin
         oq.push_back({out_ambig, out_invalid, out_data});
         ocyc.push_back(cyc);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_fail=%0d required 0", n_fail);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] w);
      bit acc = 1'b0;
      in_valid = 1'b1;
      in_data  = w;
      for (int t = 0; t < 60 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      if (!acc) chk("send_timeout", 64'(acc), 64'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_q();
      oq.delete();
      ocyc.delete();
      acyc.delete();
   endtask

   initial begin
      logic [33:0] exp1 [5];
      logic [31:0] rt_a [12];
      logic [31:0] a, b;
      bit ok;

      // ---- reset state ----
      #2;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_flags", 64'({out_ambig, out_invalid}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      idle(1);

      // ---- 1: streaming decode table ----
      clear_q();
      send(32'd10); send(32'd4096); send(32'd4097); send(32'd4098); send(32'hFFFF_FFFF);
      idle(5);
      exp1[0] = {2'b00, 32'd9};
      exp1[1] = {2'b00, 32'd4095};
      exp1[2] = {2'b10, 32'd4096};
      exp1[3] = {2'b00, 32'd4098};
      exp1[4] = {2'b00, 32'hFFFF_FFFF};
      chk("stream_count", 64'(oq.size()), 64'd5);
      for (int i = 0; i < 5 && i < oq.size() && i < acyc.size(); i++) begin
         chk($sformatf("stream_word%0d", i), 64'(oq[i]), 64'(exp1[i]));
         chk($sformatf("stream_lat%0d", i), 64'(ocyc[i] - acyc[i]), 64'd2);
      end

      // ---- 2: invalid word ----
      clear_q();
      send(32'd0);
      idle(3);
      chk("inv_count", 64'(oq.size()), 64'd1);
      if (oq.size() > 0) chk("inv_word", 64'(oq[0]), 64'({2'b01, 32'd0}));

      // ---- 3: back-pressure ----
      clear_q();
      out_ready = 1'b0;
      send(32'd100);
      send(32'd101);
      chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
      fork
         begin
            for (int i = 2; i < 8; i++) send(32'(100 + i));
         end
         begin
            for (int i = 0; i < 3; i++) begin
               idle(1);
               chk($sformatf("bp_hold%0d", i), 64'({out_valid, out_ambig, out_invalid, out_data}),
                   64'({3'b100, 32'd99}));
            end
            out_ready = 1'b1;
         end
      join
      idle(6);
      chk("bp_count", 64'(oq.size()), 64'd8);
      ok = (oq.size() == 8);
      for (int i = 0; i < 8 && i < oq.size(); i++) begin
         if (oq[i] !== {2'b00, 32'(99 + i)}) ok = 1'b0;
         if (i > 0 && (ocyc[i] - ocyc[i-1]) != 1) ok = 1'b0;
      end
      chk("bp_order_rate", 64'(ok), 64'd1);

      // ---- 4: reset mid-stream ----
      clear_q();
      send(32'd200);
      send(32'd201);
      chk("rs_pre_valid", 64'(out_valid), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("rs_out_valid", 64'(out_valid), 64'd0);
      chk("rs_out_data", 64'(out_data), 64'd0);
      chk("rs_in_ready", 64'(in_ready), 64'd1);
      idle(1);
      #2 rst_n = 1'b1;
      idle(4);
      chk("rs_no_stale", 64'(oq.size()), 64'd0);

      // ---- 5: round trip through the forward function ----
      clear_q();
      rt_a[0] = 32'd0;    rt_a[1] = 32'd1;    rt_a[2] = 32'd4095; rt_a[3] = 32'd4096;
      rt_a[4] = 32'd4097; rt_a[5] = 32'd4098; rt_a[6] = 32'hFFFF_FFFF;
      for (int i = 7; i < 12; i++) rt_a[i] = $urandom_range(8192, 0);
      foreach (rt_a[i]) begin
         a = rt_a[i];
         b = (a > 32'd4096) ? a : a + 32'd1;
         send(b);
      end
      idle(4);
      chk("rt_count", 64'(oq.size()), 64'd12);
      ok = (oq.size() == 12);
      for (int i = 0; i < 12 && i < oq.size(); i++) begin
         a = rt_a[i];
         if (oq[i][31:0] !== ((a == 32'd4097) ? 32'd4096 : a)) ok = 1'b0;
         if (oq[i][33] !== ((a == 32'd4096) || (a == 32'd4097))) ok = 1'b0;
         if (oq[i][32] !== 1'b0) ok = 1'b0;
      end
      chk("rt_values", 64'(ok), 64'd1);

`ifdef COND_DECREMENT_STATS_EN
      // ---- 6: statistics counters ----
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      chk("st_rst_ambig", 64'(ambig_cnt), 64'd0);
      chk("st_rst_invalid", 64'(invalid_cnt), 64'd0);
      out_ready = 1'b0;
      send(32'd4097);
      for (int i = 0; i < 4; i++) begin
         idle(1);
         chk($sformatf("st_stall%0d", i), 64'(ambig_cnt), 64'd0);
      end
      out_ready = 1'b1;
      send(32'd4097); send(32'd0); send(32'd4097); send(32'd0);
      idle(4);
      chk("st_ambig", 64'(ambig_cnt), 64'd3);
      chk("st_invalid", 64'(invalid_cnt), 64'd2);
      dut.ambig_cnt_q = 16'hFFFE;
      send(32'd4097); send(32'd4097);
      idle(4);
      chk("st_saturate", 64'(ambig_cnt), 64'hFFFF);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
